mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
Parametrised MEM/WB pipeline register, successor to the fixed 64-bit MEM/WB latch. It adds a valid/ready handshake, optional 2-entry skid buffering, synchronous flush and bubble masking of control signals. It also provides an x0 write guard, a registered write-back mux with forwarding taps, and a saturating stall counter. It sits between the data-memory stage and the register-file write port.

Parameters:
XLEN, 64, width of read_data, alu_result and wb_data
REG_ADDR_W, 5, width of rd
SKID, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single register (in_ready combinational)
ZERO_REG_GUARD, 1, 1 = force reg_write_out low when rd_out == 0
CNT_W, 32, width of the stall counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  MEM stage holds a valid instruction
in_ready  out  1  stage can accept this cycle
read_data  in  XLEN  data-memory load result
alu_result  in  XLEN  ALU result / address
rd  in  REG_ADDR_W  destination register
reg_write  in  1  WB control
mem_to_reg  in  1  WB control
mem_read  in  1  load marker (hazard use)
flush  in  1  synchronous kill of all held entries
out_valid  out  1  WB entry valid
out_ready  in  1  WB/regfile can consume
read_data_out  out  XLEN  registered read_data
alu_result_out  out  XLEN  registered alu_result
rd_out  out  REG_ADDR_W  registered rd
reg_write_out  out  1  masked registered reg_write
mem_to_reg_out  out  1  masked registered mem_to_reg
mem_read_out  out  1  masked registered mem_read
wb_data  out  XLEN  mem_to_reg_out ? read_data_out : alu_result_out
fwd_valid  out  1  out_valid && reg_write_out
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready

Behaviour:
- Reset (reset==0, async):
  - out_valid=0, skid_valid=0, stall_cnt=0.
  - All data and control registers are 0, including mem_read_out.
  - in_ready=1 immediately while in reset.
- Accept: in_valid && in_ready at a rising edge. Emit: out_valid && out_ready at a rising edge.
- Latency: 1 cycle in->out when there is no backpressure. Full throughput is 1 per cycle.
- SKID=0:
  - in_ready = !out_valid || out_ready.
  - Accept loads the main register. Emit without accept clears out_valid.
- SKID=1:
  - in_ready = !skid_valid (registered).
  - Accept while out_valid && !out_ready loads the skid register and sets skid_valid.
  - On emit with skid_valid: skid moves to main and skid_valid clears. A simultaneous accept is impossible, since in_ready=0.
  - On emit with no skid: main loads from the input if accepting, else out_valid clears.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- Flush:
  - Next edge clears out_valid and skid_valid; the input in that cycle is discarded.
  - Priority: reset > flush > handshake. stall_cnt is not cleared by flush.
- Bubble masking: when out_valid=0, reg_write_out, mem_to_reg_out and mem_read_out read 0. Data outputs hold their last value.
- Zero-register guard: with ZERO_REG_GUARD=1 and rd_out==0, reg_write_out=0. wb_data is still driven.
- wb_data and fwd_valid are combinational from the output registers only, with no input-to-output combinational path. in_ready depends on out_ready only when SKID=0.
- stall_cnt: increments each edge with out_valid && !out_ready. It saturates at all-ones and never wraps.
- If reset asserts mid-stall, every entry is lost. The first accept after release completes on the first rising edge with reset==1.

Decomposition:
- Shared package pipe_pkg holds:
  - Constants XLEN_DEF=64 and REG_ADDR_W_DEF=5.
  - Packed struct wb_ctrl_t {reg_write, mem_to_reg, mem_read}.
  - Packed struct mem_wb_payload_t {read_data, alu_result, rd, wb_ctrl_t}.
- Sub-module pipe_skid_reg: a generic payload-width valid/ready register with SKID and flush. mem_wb_pipe wraps it and adds masking, the write-back mux, forwarding and the counter.

Test Plan:
1. Reset held low with in_valid=1 -> all outputs 0 and in_ready=1. After release, input alu=0x10, rd=5, reg_write=1 gives, one edge later, out_valid=1, rd_out=5, wb_data=0x10 and fwd_valid=1.
2. Stream A,B,C with out_ready low for 3 cycles after A (SKID=1):
   - in_ready drops the cycle after B is skidded.
   - stall_cnt=3.
   - Outputs A,B,C are in order with no loss.
3. mem_to_reg=1, read_data=0xDEAD, alu=0xBEEF -> wb_data=0xDEAD. With mem_to_reg=0 -> wb_data=0xBEEF.
4. rd=0, reg_write=1 -> out_valid=1, reg_write_out=0, fwd_valid=0.
5. Flush with main and skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and no flushed entry is ever emitted.
6. CNT_W=4 with 20 stall cycles -> stall_cnt=15. Then async reset pulsed mid-stall -> stall_cnt=0 and out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared widths and payload types for the MEM/WB pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int XLEN_DEF       = 64;
    localparam int REG_ADDR_W_DEF = 5;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
    } wb_ctrl_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0]       read_data;
        logic [XLEN_DEF-1:0]       alu_result;
        logic [REG_ADDR_W_DEF-1:0] rd;
        wb_ctrl_t                  ctrl;
    } mem_wb_payload_t;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Generic valid/ready pipeline register, optional 2-entry skid.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int W    = 8,
    parameter int SKID = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_out_valid;
    logic [W-1:0] r_main;
    logic         w_accept;
    logic         w_emit;

    assign w_accept  = in_valid && in_ready;
    assign w_emit    = r_out_valid && out_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

    generate
        if (SKID != 0) begin : g_skid
            logic         r_skid_valid;
            logic [W-1:0] r_skid;

            // Registered ready: the skid slot absorbs the one beat in flight.
            assign in_ready = !r_skid_valid;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_out_valid  <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_main       <= '0;
                    r_skid       <= '0;
                end else if (flush) begin
                    r_out_valid  <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (w_emit) begin
                    if (r_skid_valid) begin
                        r_main       <= r_skid;
                        r_skid_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_main <= in_data;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end else if (w_accept) begin
                    if (!r_out_valid) begin
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_skid       <= in_data;
                        r_skid_valid <= 1'b1;
                    end
                end
            end
        end else begin : g_single
            assign in_ready = !r_out_valid || out_ready;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_out_valid <= 1'b0;
                    r_main      <= '0;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                end else if (w_accept) begin
                    r_main      <= in_data;
                    r_out_valid <= 1'b1;
                end else if (w_emit) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe
// Description : MEM/WB stage register with handshake, masking, WB mux, stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int SKID           = 1,
    parameter int ZERO_REG_GUARD = 1,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       read_data,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_write,
    input  logic                  mem_to_reg,
    input  logic                  mem_read,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       read_data_out,
    output logic [XLEN-1:0]       alu_result_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic                  mem_read_out,
    output logic [XLEN-1:0]       wb_data,
    output logic                  fwd_valid,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int c_CTRL_W    = $bits(wb_ctrl_t);
    localparam int c_PAYLOAD_W = 2 * XLEN + REG_ADDR_W + c_CTRL_W;

    wb_ctrl_t                 w_in_ctrl;
    wb_ctrl_t                 w_out_ctrl;
    logic [c_PAYLOAD_W-1:0]   w_in_payload;
    logic [c_PAYLOAD_W-1:0]   w_out_payload;
    logic                     w_rd_writable;
    logic [CNT_W-1:0]         r_stall_cnt;

    assign w_in_ctrl    = {reg_write, mem_to_reg, mem_read};
    assign w_in_payload = {read_data, alu_result, rd, w_in_ctrl};

    pipe_skid_reg #(
        .W    (c_PAYLOAD_W),
        .SKID (SKID)
    ) u_skid_reg (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign {read_data_out, alu_result_out, rd_out, w_out_ctrl} = w_out_payload;

    generate
        if (ZERO_REG_GUARD != 0) begin : g_zero_guard
            assign w_rd_writable = (rd_out != '0);
        end else begin : g_no_guard
            assign w_rd_writable = 1'b1;
        end
    endgenerate

    // Control bits are squashed on bubbles so a stale entry never writes back.
    assign reg_write_out  = out_valid && w_out_ctrl.reg_write && w_rd_writable;
    assign mem_to_reg_out = out_valid && w_out_ctrl.mem_to_reg;
    assign mem_read_out   = out_valid && w_out_ctrl.mem_read;

    assign wb_data   = mem_to_reg_out ? read_data_out : alu_result_out;
    assign fwd_valid = out_valid && reg_write_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_pipe
// Description : Scoreboard bench for mem_wb_pipe (SKID=1, plus a CNT_W=4 copy).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe;

    typedef struct {
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_valid4;
    logic        out_ready, out_ready4;
    logic        flush;
    logic        flush4 = 1'b0;
    logic [63:0] read_data, alu_result;
    logic [4:0]  rd;
    logic        reg_write, mem_to_reg, mem_read;

    logic        in_ready, out_valid, reg_write_out, mem_to_reg_out, mem_read_out, fwd_valid;
    logic [63:0] read_data_out, alu_result_out, wb_data;
    logic [4:0]  rd_out;
    logic [31:0] stall_cnt;

    logic        in_ready4, out_valid4, reg_write_out4, mem_to_reg_out4, mem_read_out4, fwd_valid4;
    logic [63:0] read_data_out4, alu_result_out4, wb_data4;
    logic [4:0]  rd_out4;
    logic [3:0]  stall_cnt4;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    ent_t cur;
    bit   acc;

    always #5 clk = ~clk;

    mem_wb_pipe #(.XLEN(64), .REG_ADDR_W(5), .SKID(1), .ZERO_REG_GUARD(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .read_data(read_data), .alu_result(alu_result), .rd(rd),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
        .mem_read_out(mem_read_out), .wb_data(wb_data), .fwd_valid(fwd_valid),
        .stall_cnt(stall_cnt)
    );

    mem_wb_pipe #(.XLEN(64), .REG_ADDR_W(5), .SKID(1), .ZERO_REG_GUARD(1), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .read_data(read_data), .alu_result(alu_result), .rd(rd),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .flush(flush4), .out_valid(out_valid4), .out_ready(out_ready4),
        .read_data_out(read_data_out4), .alu_result_out(alu_result_out4), .rd_out(rd_out4),
        .reg_write_out(reg_write_out4), .mem_to_reg_out(mem_to_reg_out4),
        .mem_read_out(mem_read_out4), .wb_data(wb_data4), .fwd_valid(fwd_valid4),
        .stall_cnt(stall_cnt4)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input logic [63:0] rdata, input logic [63:0] alu,
                                input logic [4:0] r, input logic rw, input logic m2r,
                                input logic mr);
        ent_t e;
        e.rdata = rdata; e.alu = alu; e.rd = r; e.rw = rw; e.m2r = m2r; e.mr = mr;
        return e;
    endfunction

    task automatic drive(input ent_t e, input logic v);
        cur        = e;
        read_data  = e.rdata;
        alu_result = e.alu;
        rd         = e.rd;
        reg_write  = e.rw;
        mem_to_reg = e.m2r;
        mem_read   = e.mr;
        in_valid   = v;
    endtask

    // Called just after a falling edge with inputs set; checks outputs, then advances one cycle.
    task automatic step(output bit accepted);
        ent_t e;
        #1;
        accepted = in_valid && in_ready && !flush;
        check_val("out_valid", out_valid, q.size() != 0);
        if (q.size() == 0) begin
            check_val("bubble_ctrl", {reg_write_out, mem_to_reg_out, mem_read_out, fwd_valid}, 0);
        end
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val("spurious_emit", 1, 0);
                end else begin
                    e = q.pop_front();
                    check_val("rd_out", rd_out, e.rd);
                    check_val("alu_out", alu_result_out, e.alu);
                    check_val("rdata_out", read_data_out, e.rdata);
                    check_val("wb_data", wb_data, e.m2r ? e.rdata : e.alu);
                    check_val("reg_write_out", reg_write_out, e.rw && (e.rd != 0));
                    check_val("fwd_valid", fwd_valid, e.rw && (e.rd != 0));
                    check_val("mem_to_reg_out", mem_to_reg_out, e.m2r);
                    check_val("mem_read_out", mem_read_out, e.mr);
                end
            end
            if (accepted) q.push_back(cur);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        out_ready4 = 1'b1;
        in_valid4  = 1'b1;
        drive(mk(64'h1234, 64'h5678, 5'd7, 1'b1, 1'b1, 1'b1), 1'b1);

        // Reset held with traffic present
        #23;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_in_ready4", in_ready4, 1);
        check_val("rst_ctrl", {reg_write_out, mem_to_reg_out, mem_read_out, fwd_valid}, 0);
        check_val("rst_data", {rd_out, read_data_out[7:0], alu_result_out[7:0]}, 0);
        check_val("rst_wb_data", wb_data, 0);
        check_val("rst_stall", stall_cnt, 0);
        in_valid4 = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Single transfer, one-cycle latency
        drive(mk(64'h0, 64'h10, 5'd5, 1'b1, 1'b0, 1'b0), 1'b1);
        step(acc);
        check_val("t1_accept", acc, 1);
        check_val("t1_out_valid", out_valid, 1);
        check_val("t1_rd_out", rd_out, 5);
        check_val("t1_wb_data", wb_data, 64'h10);
        check_val("t1_fwd", fwd_valid, 1);
        in_valid = 1'b0;
        step(acc);
        step(acc);

        // A,B,C with three stalled cycles after A
        drive(mk(64'hA0, 64'hA1, 5'd1, 1'b1, 1'b0, 1'b0), 1'b1);
        step(acc);
        out_ready = 1'b0;
        drive(mk(64'hB0, 64'hB1, 5'd2, 1'b1, 1'b1, 1'b1), 1'b1);
        step(acc);
        check_val("t2_b_accept", acc, 1);
        drive(mk(64'hC0, 64'hC1, 5'd3, 1'b0, 1'b0, 1'b1), 1'b1);
        check_val("t2_in_ready_low", in_ready, 0);
        step(acc);
        step(acc);
        check_val("t2_stall_cnt", stall_cnt, 3);
        out_ready = 1'b1;
        step(acc);
        check_val("t2_c_blocked", acc, 0);
        step(acc);
        check_val("t2_c_accept", acc, 1);
        in_valid = 1'b0;
        step(acc);
        step(acc);
        check_val("t2_drained", q.size(), 0);

        // Write-back mux and x0 guard, back to back
        drive(mk(64'hDEAD, 64'hBEEF, 5'd9, 1'b1, 1'b1, 1'b1), 1'b1);
        step(acc);
        check_val("t3_wb_load", wb_data, 64'hDEAD);
        drive(mk(64'hDEAD, 64'hBEEF, 5'd9, 1'b1, 1'b0, 1'b0), 1'b1);
        step(acc);
        check_val("t3_wb_alu", wb_data, 64'hBEEF);
        drive(mk(64'h77, 64'h88, 5'd0, 1'b1, 1'b0, 1'b0), 1'b1);
        step(acc);
        check_val("t4_rd0_valid", out_valid, 1);
        check_val("t4_rd0_rw", reg_write_out, 0);
        check_val("t4_rd0_fwd", fwd_valid, 0);
        in_valid = 1'b0;
        step(acc);
        step(acc);

        // Flush with main and skid occupied and a new input offered
        out_ready = 1'b0;
        drive(mk(64'h5A, 64'h5B, 5'd10, 1'b1, 1'b0, 1'b0), 1'b1);
        step(acc);
        drive(mk(64'h6A, 64'h6B, 5'd11, 1'b1, 1'b1, 1'b0), 1'b1);
        step(acc);
        flush = 1'b1;
        drive(mk(64'h7A, 64'h7B, 5'd12, 1'b1, 1'b0, 1'b1), 1'b1);
        step(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("t5_out_valid", out_valid, 0);
        check_val("t5_in_ready", in_ready, 1);
        check_val("t5_stall_kept", stall_cnt, 5);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(acc);

        // Saturating 4-bit counter, then async reset mid-stall
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        drive(mk(64'h91, 64'h92, 5'd13, 1'b1, 1'b0, 1'b0), 1'b0);
        step(acc);
        in_valid4 = 1'b0;
        for (int i = 0; i < 10; i++) step(acc);
        check_val("t6_cnt10", stall_cnt4, 10);
        for (int i = 0; i < 10; i++) step(acc);
        check_val("t6_cnt_sat", stall_cnt4, 15);
        check_val("t6_valid4", out_valid4, 1);
        #2;
        reset = 1'b0;
        #1;
        check_val("t6_rst_cnt4", stall_cnt4, 0);
        check_val("t6_rst_valid4", out_valid4, 0);
        check_val("t6_rst_ready4", in_ready4, 1);
        check_val("t6_rst_cnt", stall_cnt, 0);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        drive(mk(64'hE0, 64'hE1, 5'd14, 1'b1, 1'b0, 1'b0), 1'b1);
        step(acc);
        check_val("t6_first_accept", acc, 1);
        in_valid = 1'b0;
        step(acc);
        step(acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
